// File: rtl/aqp_esp_uart_pkg.sv
// Shared ESP UART definitions: data width, oversampling constants used by
// the RX/TX, and the RX FIFO status bundle.
package aqp_esp_uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_OVERSAMPLE   = 8;
  localparam int UART_SAMPLE_POINT = 4;

  typedef struct packed {
    logic overflow;
    logic ferr;
    logic full;
    logic empty;
  } uart_rx_status_t;

endpackage

// File: rtl/aqp_esp_uart_rx_fifo_mem.sv
// Simple dual-port storage for the RX FIFO. Synchronous write and
// asynchronous read, so it maps onto distributed RAM. Contents are not reset.
module aqp_esp_uart_rx_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: one byte per clock when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aqp_esp_uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the ESP UART receiver, with sticky
// overflow / framing-error status, flush and status-clear strobes.
// Optional fill-level interrupt: define AQP_ESP_UART_RX_FIFO_IRQ_EN.
module aqp_esp_uart_rx_fifo
  import aqp_esp_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   framing_error,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   overflow,
  output logic                   ferr,
  input  logic                   flush,
  input  logic                   status_clr,
  output logic                   irq
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8) begin : g_bad_depth
    $error("aqp_esp_uart_rx_fifo: DEPTH_LOG2 out of range 2..8");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > 2**DEPTH_LOG2) begin : g_bad_irq_level
    $error("aqp_esp_uart_rx_fifo: IRQ_LEVEL out of range");
  end

  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic                   ovf_q;
  logic                   ferr_q;
  logic                   q_ferr_d;
  logic                   push;
  logic                   pop;
  logic                   ovf_set;
  logic                   ferr_set;
  logic [UART_DATA_W-1:0] mem_rdata;
  uart_rx_status_t        status;

  assign status = '{overflow: ovf_q,
                    ferr:     ferr_q,
                    full:     (count == DEPTH_CNT),
                    empty:    (count == '0)};

  assign overflow = status.overflow;
  assign ferr     = status.ferr;
  assign full     = status.full;
  assign empty    = status.empty;

  // Flush dominates; a pop frees a slot so a full FIFO still accepts a byte.
  assign pop      = rd_en && !empty && !flush;
  assign push     = rx_valid && (!full || pop) && !flush;
  assign ovf_set  = rx_valid && full && !pop && !flush;
  assign ferr_set = framing_error && !q_ferr_d;

  aqp_esp_uart_rx_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (UART_DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Head byte is meaningless while empty; force 0 so it is deterministic.
  assign rd_data = empty ? '0 : mem_rdata;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Sticky status flags; a set event in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      q_ferr_d <= 1'b0;
    end else begin
      q_ferr_d <= framing_error;
      ovf_q    <= ovf_set  || (ovf_q  && !status_clr);
      ferr_q   <= ferr_set || (ferr_q && !status_clr);
    end
  end

`ifdef AQP_ESP_UART_RX_FIFO_IRQ_EN
  localparam logic [DEPTH_LOG2:0] IRQ_CNT = (DEPTH_LOG2+1)'(IRQ_LEVEL);

  // Fill-level interrupt, one clock behind count/overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (count >= IRQ_CNT) || ovf_q;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_aqp_esp_uart_rx_fifo.sv
// Self-checking bench for aqp_esp_uart_rx_fifo (DEPTH_LOG2=4, IRQ_LEVEL=8).
module tb_aqp_esp_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int IRQL  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          framing_error;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          ferr;
  logic          flush;
  logic          status_clr;
  logic          irq;

  aqp_esp_uart_rx_fifo #(.DEPTH_LOG2(DL), .IRQ_LEVEL(IRQL)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .framing_error (framing_error),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overflow      (overflow),
    .ferr          (ferr),
    .flush         (flush),
    .status_clr    (status_clr),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of stored bytes plus flag bits.
  byte unsigned mq[$];
  byte unsigned exp_q[$];
  bit m_ovf, m_ferr, m_irq, m_fe_prev;

  function automatic void chk(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
  endfunction

  task automatic check_state();
    chk("count",    int'(count),    mq.size());
    chk("empty",    int'(empty),    int'(mq.size() == 0));
    chk("full",     int'(full),     int'(mq.size() == DEPTH));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("ferr",     int'(ferr),     int'(m_ferr));
    chk("irq",      int'(irq),      int'(m_irq));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 0; m_ferr = 0; m_irq = 0; m_fe_prev = 0;
  endtask

  // One clock of stimulus; the model applies the same cycle, then state is compared.
  task automatic step(bit rv, byte unsigned d, bit fe, bit rd, bit fl, bit clr);
    int pre_sz;
    bit pre_ovf, pop_m, ovf_set, ferr_set;
    pre_sz  = mq.size();
    pre_ovf = m_ovf;
    rx_valid = rv; rx_data = d; framing_error = fe;
    rd_en = rd; flush = fl; status_clr = clr;
    pop_m   = rd && (pre_sz > 0) && !fl;
    ovf_set = 0;
    if (fl) mq.delete();
    else begin
      if (pop_m) exp_q.push_back(mq.pop_front());
      if (rv) begin
        if (pre_sz < DEPTH || pop_m) mq.push_back(d);
        else ovf_set = 1;
      end
    end
    ferr_set  = fe && !m_fe_prev;
    m_fe_prev = fe;
    m_ovf  = ovf_set  | (m_ovf  & !clr);
    m_ferr = ferr_set | (m_ferr & !clr);
`ifdef AQP_ESP_UART_RX_FIFO_IRQ_EN
    m_irq = (pre_sz >= IRQL) || pre_ovf;
`else
    m_irq = 0;
`endif
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic push(byte unsigned d); step(1, d, 0, 0, 0, 0); endtask
  task automatic pop();                 step(0, 0, 0, 1, 0, 0); endtask
  task automatic idle();                step(0, 0, 0, 0, 0, 0); endtask

  // Monitor: every accepted pop presents a head byte that must match the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rd_en && !empty && !flush) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else                   chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; rx_data = 0; rx_valid = 0; framing_error = 0;
    rd_en = 0; flush = 0; status_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("reset_rd_data", int'(rd_data), 0);
    reset = 0;
    idle();

    // Three bytes in, three out.
    push(8'h41); push(8'h42); push(8'h43);
    chk("head_after_3", int'(rd_data), 8'h41);
    pop(); pop(); pop();
    pop();  // pop while empty is ignored

    // Overfill: 17 pushes, drain.
    for (int i = 0; i <= 16; i++) push(byte'(i));
    for (int i = 0; i < 17; i++) pop();

    // Full with simultaneous push and pop.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) push(byte'(8'h80 + i));
    step(1, 8'hA5, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) pop();

    // Framing error pulse and clear interactions.
    push(8'h11);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);  // clear coincident with new rise
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    pop();

    // Flush coincident with an incoming byte.
    for (int i = 0; i < 5; i++) push(byte'(8'h20 + i));
    step(1, 8'h55, 0, 1, 1, 0);
    push(8'h66);
    chk("head_after_flush", int'(rd_data), 8'h66);
    pop();

    // Interrupt threshold walk.
    for (int i = 0; i < 7; i++) push(byte'(8'h30 + i));
    idle();
    push(8'h37);
    idle();
    pop();
    idle();
    step(0, 0, 0, 0, 1, 0);
    idle();

    // Randomised traffic with phases biased toward filling and draining.
    for (int ph = 0; ph < 8; ph++) begin
      int rd_pct;
      rd_pct = (ph % 2 == 0) ? 15 : 70;
      for (int i = 0; i < 300; i++) begin
        bit rv, rd, fl, clr, fe;
        rv  = ($urandom_range(99) < 50);
        rd  = ($urandom_range(99) < rd_pct);
        fl  = ($urandom_range(199) == 0);
        clr = ($urandom_range(39) == 0);
        fe  = ($urandom_range(19) == 0) ? !m_fe_prev : m_fe_prev;
        step(rv, byte'($urandom_range(255)), fe, rd, fl, clr);
      end
    end
    step(0, 0, 0, 0, 0, 1);

    // Reset in the middle of operation.
    push(8'hC1); push(8'hC2); push(8'hC3);
    reset = 1;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    reset = 0;
    idle();
    push(8'hD0);
    pop();
    idle();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aqp_esp_uart_rx_fifo.md
Name: aqp_esp_uart_rx_fifo

Overview:
- Downstream consumer of the ESP UART receiver.
- Buffers received bytes (rx_data/rx_valid) in a first-word-fall-through FIFO for the CPU/IO-register side.
- Keeps sticky overflow and framing-error status, and has flush and status-clear controls.
- Sits between the UART RX and the ESP IO-register decode.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 bytes (default 16). Legal range 2..8.
- IRQ_LEVEL, 8: fill threshold for irq; used only with the optional feature. Legal range 1..2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock, same domain as the UART RX.
- reset  in  1  async active-high reset.
- rx_data  in  8  received byte from the UART RX.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- framing_error  in  1  level from the UART RX; high while the stop bit is bad.
- rd_en  in  1  pop strobe from the IO-register read.
- rd_data  out  8  head of FIFO (FWFT); valid when empty=0.
- empty  out  1  FIFO holds 0 bytes.
- full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
- count  out  DEPTH_LOG2+1  number of bytes held.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- ferr  out  1  sticky: a framing error occurred.
- flush  in  1  one-cycle strobe; discards all contents.
- status_clr  in  1  one-cycle strobe; clears overflow and ferr.
- irq  out  1  fill-level interrupt; tied 0 without the optional feature.

Behaviour:
- Reset (async, reset=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, ferr=0, irq=0. rd_data is don't-care while empty (sim shows 0 after reset). Storage contents are not reset.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is a separate register, not derived from pointers.
- empty = (count==0), full = (count==2**DEPTH_LOG2); both are combinational from count.
- Write: push when rx_valid=1 and (full=0 or pop this cycle). Store at wr_ptr, wr_ptr+1. Visible at rd_data the next cycle when previously empty (write-to-read latency 1 clk).
- Read: pop when rd_en=1 and empty=0, rd_ptr+1. rd_data = mem[rd_ptr], combinational read. rd_en while empty is ignored; no underflow flag, no state change.
- Simultaneous push and pop:
  - Non-empty, non-full: both happen, count unchanged.
  - Full: both happen, no overflow, count stays full.
  - Empty: push only, pop ignored, count=1.
- Overflow: rx_valid=1 while full with no pop. Byte dropped, overflow<=1, pointers and count unchanged.
- ferr: set on the rising edge of framing_error (registered previous value q_ferr_d). Does not affect the FIFO contents.
- flush: highest priority, the next clock gives wr_ptr=rd_ptr=0 and count=0. A same-cycle rx_valid byte is dropped without setting overflow. A same-cycle rd_en is ignored. Sticky flags are unaffected.
- status_clr: overflow<=0, ferr<=0. A set event in the same cycle wins: flag ends 1.
- flush and status_clr may assert together; each acts independently.
- Reset mid-operation: all state returns to reset values immediately; any byte in flight upstream is lost.
- count increments by at most 1 per clock. The upstream byte rate (one per 80 clks minimum) never exceeds that.

Optional Feature:
- Macro AQP_ESP_UART_RX_FIFO_IRQ_EN.
- Defined: irq is registered and equals (count >= IRQ_LEVEL) OR overflow, updated one clock after count/overflow change.
- Undefined: irq is constant 0 and there is no comparator logic. IRQ_LEVEL is ignored.

Decomposition:
- Package aqp_esp_uart_pkg holds:
  - UART_DATA_W=8;
  - UART_OVERSAMPLE=8 and UART_SAMPLE_POINT=4 (shared with the UART RX/TX);
  - a typedef for a status struct {overflow, ferr, full, empty}.
- Natural sub-module: aqp_esp_uart_rx_fifo_mem. It is a simple dual-port array of 2**DEPTH_LOG2 x 8, with a synchronous write port and an async read port, and infers distributed RAM.
- Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset then 3 pushes 0x41,0x42,0x43 -> count=3, rd_data=0x41. Three rd_en -> rd_data 0x42, 0x43, then empty=1, count=0.
- Push 17 bytes 0x00..0x10 into DEPTH_LOG2=4 -> full=1 after 16, overflow=1 after the 17th. Reads return 0x00..0x0F; 0x10 is absent.
- Fill to full, then rx_valid=1 with rd_en=1 in the same cycle -> no overflow, count=16, last byte read back after the 15 older bytes.
- framing_error pulse high for 5 clks -> ferr=1, count unchanged. status_clr -> ferr=0. status_clr coincident with a new framing_error rise -> ferr=1.
- 5 bytes queued, flush coincident with rx_valid(0x55) -> next clk count=0, empty=1, overflow=0. Subsequent push 0x66 -> rd_data=0x66.
- With AQP_ESP_UART_RX_FIFO_IRQ_EN, IRQ_LEVEL=8: irq=0 at 7 bytes, 1 one clk after the 8th push, 0 after one pop. Without the macro, irq stays 0 throughout.
